// File: rtl/perf_counter_reader_pkg.sv
// Shared constants and types for the performance counter reader.
// CSR map, FSM state type and the address decode helper.
package perf_counter_reader_pkg;

  localparam int NUM_CTR = 5;
  localparam int ADDR_W  = 12;

  localparam logic [ADDR_W-1:0] CSR_CYCLE     = 12'hC00;
  localparam logic [ADDR_W-1:0] CSR_INSTRET   = 12'hC02;
  localparam logic [ADDR_W-1:0] CSR_STALL     = 12'hC03;
  localparam logic [ADDR_W-1:0] CSR_BRANCH    = 12'hC04;
  localparam logic [ADDR_W-1:0] CSR_MISPRED   = 12'hC05;
  localparam logic [ADDR_W-1:0] CSR_HI_OFFSET = 12'h080;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  typedef struct packed {
    logic       hit;
    logic       high;
    logic [2:0] idx;
  } dec_t;

  function automatic dec_t lo_decode(
    input logic [ADDR_W-1:0] addr
  );
    dec_t d;
    d = '0;
    case (addr)
      CSR_CYCLE:   begin d.hit = 1'b1; d.idx = 3'd0; end
      CSR_INSTRET: begin d.hit = 1'b1; d.idx = 3'd1; end
      CSR_STALL:   begin d.hit = 1'b1; d.idx = 3'd2; end
      CSR_BRANCH:  begin d.hit = 1'b1; d.idx = 3'd3; end
      CSR_MISPRED: begin d.hit = 1'b1; d.idx = 3'd4; end
      default:     d = '0;
    endcase
    return d;
  endfunction

  function automatic dec_t csr_decode(
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W-1:0] hi_off
  );
    dec_t dl;
    dec_t dh;
    dl = lo_decode(addr);
    dh = lo_decode(addr - hi_off);
    if (dl.hit) begin
      return dl;
    end
    if (dh.hit) begin
      dh.high = 1'b1;
      return dh;
    end
    return '0;
  endfunction

endpackage

// File: rtl/perf_counter_reader_hi_ext.sv
// Extends one 32-bit live counter to 64 bits.
// Counts 0xFFFF_FFFF -> 0 transitions into a silent-wrap hi word.
module counter_hi_ext (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lo,
  output logic [31:0] hi
);

  logic [31:0] prev_lo;
  logic        wrap;

  assign wrap = (prev_lo == 32'hFFFF_FFFF) && (lo == 32'h0);

  // Remember last low word; bump hi only on a true roll-over.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_lo <= '0;
      hi      <= '0;
    end else begin
      prev_lo <= lo;
      if (wrap) begin
        hi <= hi + 32'd1;
      end
    end
  end

endmodule

// File: rtl/perf_counter_reader.sv
// Read-side responder for the core performance counters.
// One outstanding CSR read; lo reads snapshot hi for coherent 64-bit reads.
module perf_counter_reader
  import perf_counter_reader_pkg::*;
#(
  parameter int                NUM_CTR   = perf_counter_reader_pkg::NUM_CTR,
  parameter int                ADDR_W    = perf_counter_reader_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] HI_OFFSET = CSR_HI_OFFSET
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       cycle_lo,
  input  logic [31:0]       instret_lo,
  input  logic [31:0]       stall_lo,
  input  logic [31:0]       branch_lo,
  input  logic [31:0]       mispred_lo,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_err
);

  logic [31:0] lo        [NUM_CTR];
  logic [31:0] hi        [NUM_CTR];
  logic [31:0] shadow_hi [NUM_CTR];
  logic        shadow_v  [NUM_CTR];

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  dec_t        dec;
  logic [31:0] rd_data;
  logic        rd_err;

  assign lo[0] = cycle_lo;
  assign lo[1] = instret_lo;
  assign lo[2] = stall_lo;
  assign lo[3] = branch_lo;
  assign lo[4] = mispred_lo;

  for (genvar g = 0; g < NUM_CTR; g++) begin : g_ext
    counter_hi_ext u_ext (
      .clk   (clk),
      .reset (reset),
      .lo    (lo[g]),
      .hi    (hi[g])
    );
  end

  assign dec    = csr_decode(req_addr, HI_OFFSET);
  assign accept = req_valid && req_ready;

  // Response value for the request presented this cycle.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (req_write || !dec.hit) begin
      rd_err = 1'b1;
    end else begin
      for (int n = 0; n < NUM_CTR; n++) begin
        if (dec.idx == 3'(n)) begin
          if (!dec.high) begin
            rd_data = lo[n];
          end else if (shadow_v[n]) begin
            rd_data = shadow_hi[n];
          end else begin
            rd_data = hi[n];
          end
        end
      end
    end
  end

  // Handshake state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture response on accept; held stable until consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else if (accept) begin
      resp_data <= rd_data;
      resp_err  <= rd_err;
    end
  end

  // Lo read snapshots pre-edge hi; hi read consumes the snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NUM_CTR; n++) begin
        shadow_hi[n] <= '0;
        shadow_v[n]  <= 1'b0;
      end
    end else if (accept && !req_write && dec.hit) begin
      for (int n = 0; n < NUM_CTR; n++) begin
        if (dec.idx == 3'(n)) begin
          if (!dec.high) begin
            shadow_hi[n] <= hi[n];
            shadow_v[n]  <= 1'b1;
          end else begin
            shadow_v[n]  <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_reader.sv
// Self-checking bench for perf_counter_reader.
// Directed scenarios followed by randomized traffic against a 64-bit model.
module tb_perf_counter_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lo_d [5];
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic        req_write;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  always #5 clk = ~clk;

  perf_counter_reader dut (
    .clk        (clk),
    .reset      (reset),
    .cycle_lo   (lo_d[0]),
    .instret_lo (lo_d[1]),
    .stall_lo   (lo_d[2]),
    .branch_lo  (lo_d[3]),
    .mispred_lo (lo_d[4]),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit [11:0] lo_addr [5] = '{12'hC00, 12'hC02, 12'hC03, 12'hC04, 12'hC05};

  bit [31:0] hi_m   [5];
  bit [31:0] last_m [5];
  bit [31:0] snap_m [5];
  bit        snap_v [5];
  bit        busy_m;
  bit [31:0] exp_data;
  bit        exp_err;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic clear_model();
    for (int n = 0; n < 5; n++) begin
      hi_m[n]   = '0;
      last_m[n] = '0;
      snap_m[n] = '0;
      snap_v[n] = 1'b0;
    end
    busy_m   = 1'b0;
    exp_data = '0;
    exp_err  = 1'b0;
  endtask

  task automatic predict();
    int  idx;
    bit  high;
    idx  = -1;
    high = 1'b0;
    for (int n = 0; n < 5; n++) begin
      if (req_addr == lo_addr[n]) begin
        idx = n;
        high = 1'b0;
      end
      if (req_addr == lo_addr[n] + 12'h080) begin
        idx = n;
        high = 1'b1;
      end
    end
    exp_data = '0;
    exp_err  = 1'b0;
    if (req_write || idx < 0) begin
      exp_err = 1'b1;
    end else if (!high) begin
      exp_data    = lo_d[idx];
      snap_m[idx] = hi_m[idx];
      snap_v[idx] = 1'b1;
    end else begin
      exp_data    = snap_v[idx] ? snap_m[idx] : hi_m[idx];
      snap_v[idx] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) begin
      clear_model();
    end else begin
      if (!busy_m && req_valid) begin
        predict();
        busy_m = 1'b1;
      end else if (busy_m && resp_ready) begin
        busy_m = 1'b0;
      end
      for (int n = 0; n < 5; n++) begin
        if (last_m[n] == 32'hFFFF_FFFF && lo_d[n] == 32'h0) begin
          hi_m[n] = hi_m[n] + 1;
        end
        last_m[n] = lo_d[n];
      end
    end
    #1;
    chk("req_ready", 32'(req_ready), 32'(!busy_m));
    chk("resp_valid", 32'(resp_valid), 32'(busy_m));
    if (busy_m || reset) begin
      chk("resp_data", resp_data, exp_data);
      chk("resp_err", 32'(resp_err), 32'(exp_err));
    end
    @(negedge clk);
  endtask

  task automatic rd(input logic [11:0] a, input bit wr, input int hold,
                    output logic [31:0] d, output logic e);
    req_valid  = 1'b1;
    req_addr   = a;
    req_write  = wr;
    resp_ready = 1'b0;
    step();
    d = resp_data;
    e = resp_err;
    req_addr  = 12'hC00;
    req_write = 1'b0;
    req_valid = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      step();
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    step();
  endtask

  logic [31:0] d;
  logic        e;

  initial begin
    clear_model();
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_write  = 1'b0;
    resp_ready = 1'b1;
    for (int n = 0; n < 5; n++) lo_d[n] = '0;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    step();

    lo_d[0] = 32'h1234_5678;
    rd(12'hC00, 1'b0, 0, d, e);
    chk("cycle_lo_read", d, 32'h1234_5678);
    chk("cycle_lo_err", 32'(e), 32'd0);

    lo_d[1] = 32'hFFFF_FFFF; step();
    lo_d[1] = 32'h0;         step();
    rd(12'hC82, 1'b0, 0, d, e);
    chk("instret_hi_1", d, 32'd1);
    lo_d[1] = 32'hFFFF_FFFF; step();
    lo_d[1] = 32'h0;         step();
    rd(12'hC82, 1'b0, 0, d, e);
    chk("instret_hi_2", d, 32'd2);

    lo_d[0] = 32'hFFFF_FFFF;
    rd(12'hC00, 1'b0, 0, d, e);
    chk("snap_lo", d, 32'hFFFF_FFFF);
    lo_d[0] = 32'h0; step();
    rd(12'hC80, 1'b0, 0, d, e);
    chk("snap_hi_shadow", d, 32'd0);
    rd(12'hC80, 1'b0, 0, d, e);
    chk("snap_hi_live", d, 32'd1);

    lo_d[2] = 32'hABCD_0001;
    rd(12'hC03, 1'b0, 5, d, e);
    chk("bp_data", d, 32'hABCD_0001);
    lo_d[3] = 32'h0000_0042;
    rd(12'hC04, 1'b0, 0, d, e);
    chk("bp_next", d, 32'h0000_0042);

    rd(12'hC00, 1'b1, 0, d, e);
    chk("wr_err", 32'(e), 32'd1);
    chk("wr_data", d, 32'd0);
    rd(12'hC01, 1'b0, 0, d, e);
    chk("c01_err", 32'(e), 32'd1);
    rd(12'h300, 1'b0, 0, d, e);
    chk("300_err", 32'(e), 32'd1);

    req_valid = 1'b1; req_addr = 12'hC02; req_write = 1'b0;
    resp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    step();
    reset = 1'b0;
    resp_ready = 1'b1;
    step();
    rd(12'hC80, 1'b0, 0, d, e);
    chk("rst_hi0", d, 32'd0);
    rd(12'hC82, 1'b0, 0, d, e);
    chk("rst_hi1", d, 32'd0);

    for (int t = 0; t < 400; t++) begin
      int r;
      for (int n = 0; n < 5; n++) begin
        case ($urandom_range(0, 7))
          0:       lo_d[n] = 32'hFFFF_FFFF;
          1:       lo_d[n] = 32'h0;
          2:       lo_d[n] = $urandom;
          default: lo_d[n] = lo_d[n] + 1;
        endcase
      end
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        rd(lo_addr[$urandom_range(0, 4)], 1'b0,
           $urandom_range(0, 3), d, e);
      end else if (r <= 7) begin
        rd(lo_addr[$urandom_range(0, 4)] + 12'h080, 1'b0,
           $urandom_range(0, 3), d, e);
      end else if (r == 8) begin
        rd(12'($urandom), 1'b0, $urandom_range(0, 2), d, e);
      end else begin
        rd(lo_addr[$urandom_range(0, 4)], 1'b1, 0, d, e);
      end
      if ($urandom_range(0, 3) == 0) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
